// File: rtl/key_inv_expander.sv
// ============================================================================
//  Module      : key_inv_expander
//  Description : AES-128 decryption key schedule; walks round keys RK10->RK0,
//                optionally expanding forward from the cipher key first.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_inv_expander #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         load_last,
  input  logic         next,
  input  logic [127:0] key_in,
  output logic [127:0] key_out,
  output logic [3:0]   round,
  output logic         ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;

  localparam logic [3:0] c_last = 4'(NR);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = x;
    e    = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic [1:0]   r_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic         r_ready;

  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_w1p, w_w2p, w_w3p;
  logic [31:0]  w_sub_in, w_rot, w_sub, w_t;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [3:0]   w_rcon_idx;
  logic         w_fwd_sel;
  logic [127:0] w_fwd, w_inv;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  assign w_w3p = w_w3 ^ w_w2;
  assign w_w2p = w_w2 ^ w_w1;
  assign w_w1p = w_w1 ^ w_w0;

  // One SubWord shared by both directions; only the source word and Rcon index differ
  assign w_fwd_sel  = (r_state == S_EXPAND);
  assign w_sub_in   = w_fwd_sel ? w_w3 : w_w3p;
  assign w_rcon_idx = w_fwd_sel ? (r_round + 4'd1) : r_round;
  assign w_rot      = {w_sub_in[23:0], w_sub_in[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign w_sub[8*gi +: 8] = sbox(w_rot[8*gi +: 8]);
    end
  endgenerate

  assign w_t = w_sub ^ {rcon(w_rcon_idx), 24'h000000};

  // The new w0 has the same form in both directions
  assign w_f0 = w_w0 ^ w_t;
  assign w_f1 = w_w1 ^ w_f0;
  assign w_f2 = w_w2 ^ w_f1;
  assign w_f3 = w_w3 ^ w_f2;

  assign w_fwd = {w_f0, w_f1, w_f2, w_f3};
  assign w_inv = {w_f0, w_w1p, w_w2p, w_w3p};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_round <= 4'd0;
      r_ready <= 1'b0;
    end else if (load) begin
      r_state <= S_EXPAND;
      r_key   <= key_in;
      r_round <= 4'd0;
      r_ready <= 1'b0;
    end else if (load_last) begin
      r_state <= S_READY;
      r_key   <= key_in;
      r_round <= c_last;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EXPAND: begin
          r_key   <= w_fwd;
          r_round <= r_round + 4'd1;
          if (r_round == c_last - 4'd1) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end
        end
        S_READY: begin
          if (next && (r_round != 4'd0)) begin
            r_key   <= w_inv;
            r_round <= r_round - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_out = r_key;
  assign round   = r_round;
  assign ready   = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_key_inv_expander.sv
// ============================================================================
//  Module      : tb_key_inv_expander
//  Description : Self-checking bench: per-cycle comparison against a
//                round-key-table model plus literal FIPS-197 key checks.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_inv_expander;

  logic         clk;
  logic         rst;
  logic         load;
  logic         load_last;
  logic         next;
  logic [127:0] key_in;
  logic [127:0] key_out;
  logic [3:0]   round;
  logic         ready;

  key_inv_expander #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_last (load_last),
    .next      (next),
    .key_in    (key_in),
    .key_out   (key_out),
    .round     (round),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] c_rk0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_rk1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] c_rk4  = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] c_rk9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] c_rk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [7:0] sb [0:255];

  // S-box generated from the field generator walk, independent of any inverse formula
  initial begin
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  end

  function automatic logic [7:0] rc(input int r);
    logic [7:0] v;
    v = 8'h01;
    for (int j = 1; j < r; j++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    return v;
  endfunction

  function automatic logic [31:0] g_fn(input logic [31:0] w, input int r);
    logic [31:0] rw;
    rw = {w[23:0], w[31:24]};
    return {sb[rw[31:24]] ^ rc(r), sb[rw[23:16]], sb[rw[15:8]], sb[rw[7:0]]};
  endfunction

  function automatic logic [127:0] fwd_round(input logic [127:0] k, input int r);
    logic [31:0] a, b, c, d;
    a = k[127:96] ^ g_fn(k[31:0], r);
    b = k[95:64] ^ a;
    c = k[63:32] ^ b;
    d = k[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] k, input int r);
    logic [31:0] a, b, c, d;
    d = k[31:0] ^ k[63:32];
    c = k[63:32] ^ k[95:64];
    b = k[95:64] ^ k[127:96];
    a = k[127:96] ^ g_fn(d, r);
    return {a, b, c, d};
  endfunction

  // Model: full table of round keys plus the index currently presented
  logic [127:0] rk [0:10];
  int m_state = 0;  // 0 idle, 1 expanding, 2 ready
  int m_round = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0;
      m_round = 0;
    end else if (load) begin
      rk[0] = key_in;
      for (int r = 1; r <= 10; r++) rk[r] = fwd_round(rk[r-1], r);
      m_state = 1;
      m_round = 0;
    end else if (load_last) begin
      rk[10] = key_in;
      for (int r = 10; r >= 1; r--) rk[r-1] = inv_round(rk[r], r);
      m_state = 2;
      m_round = 10;
    end else if (m_state == 1) begin
      m_round++;
      if (m_round == 10) m_state = 2;
    end else if (m_state == 2 && next && m_round > 0) begin
      m_round--;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [127:0] ek;
      logic         erdy;
      ek   = (m_state == 0) ? 128'h0 : rk[m_round];
      erdy = (m_state == 2);
      checks++;
      if (key_out !== ek || round !== 4'(m_round) || ready !== erdy) begin
        errors++;
        $display("FAIL model t=%0t: got key=%h round=%0d ready=%b, want key=%h round=%0d ready=%b",
                 $time, key_out, round, ready, ek, m_round, erdy);
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_ready(input string name, input int want);
    int cnt;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check(name, 128'(cnt), 128'(want));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_last = 1'b0; next = 1'b0; key_in = '0;
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_key", key_out, 128'h0);
    check("reset_round_ready", {round, ready}, 5'h00);

    // next in idle does nothing
    next = 1'b1;
    tick(3);
    next = 1'b0;
    check("idle_next", {key_out, round, ready}, 133'h0);

    // forward expansion from the cipher key
    key_in = c_rk0; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("load_round0", {round, ready}, 5'h00);
    wait_ready("expand_latency", 10);
    check("rk10", key_out, c_rk10);
    check("rk10_round", 128'(round), 128'd10);

    // walk backward with next held high
    next = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 1)  check("rk9", key_out, c_rk9);
      if (k == 6)  check("rk4", key_out, c_rk4);
      if (k == 9)  check("rk1", key_out, c_rk1);
      if (k == 10) check("rk0", key_out, c_rk0);
      if (k == 12) check("rk0_hold", {key_out, round, ready}, {c_rk0, 4'd0, 1'b1});
    end
    next = 1'b0;

    // direct start from RK10
    key_in = c_rk10; load_last = 1'b1;
    tick(1);
    load_last = 1'b0;
    check("load_last_state", {round, ready}, {4'd10, 1'b1});
    next = 1'b1;
    tick(1);
    next = 1'b0;
    check("load_last_rk9", key_out, c_rk9);

    // restart mid-expansion
    key_in = c_rk0; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(5);
    check("mid_round5", 128'(round), 128'd5);
    load = 1'b1;
    tick(1);
    load = 1'b0;
    check("restart_state", {key_out, round, ready}, {c_rk0, 4'd0, 1'b0});
    wait_ready("restart_latency", 10);
    check("restart_rk10", key_out, c_rk10);

    // load beats load_last
    key_in = c_rk0; load = 1'b1; load_last = 1'b1;
    tick(1);
    load = 1'b0; load_last = 1'b0;
    check("load_vs_last", {round, ready}, 5'h00);
    wait_ready("both_latency", 10);

    // load beats next in READY
    next = 1'b1; load = 1'b1;
    tick(1);
    next = 1'b0; load = 1'b0;
    check("load_vs_next", {round, ready}, 5'h00);

    // reset abandons expansion
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_expand", {key_out, round, ready}, 133'h0);
    tick(12);
    check("rst_stays_idle", {key_out, round, ready}, 133'h0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
